// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between instruction fetch and data access,
// with per-width store formatting, load extraction and an access timeout.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_width,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAcc, StResp} stateT;

    stateT         state;
    logic [CW-1:0] cnt;
    logic          lastData;   // 1 when the most recent grant went to the data port
    logic          grantData;
    logic [2:0]    width;
    logic [1:0]    offset;

    logic          pickData;
    logic          widthOk;
    logic          dMisaligned;
    logic [3:0]    fmtStrb;
    logic [31:0]   fmtData;
    logic [7:0]    selByte;
    logic [15:0]   selHalf;
    logic [31:0]   loadData;

    assign stall_if  = if_req & ~if_done;
    assign stall_mem = d_req & ~d_done;

    // Data wins a tie unless it also won the previous grant.
    assign pickData = d_req & (~if_req | ~lastData);

    always_comb begin
        widthOk     = 1'b0;
        dMisaligned = 1'b0;
        fmtStrb     = 4'b0000;
        fmtData     = d_wdata;
        case (d_width)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: widthOk = 1'b1;
            default:                                widthOk = 1'b0;
        endcase
        case (d_width[1:0])
            2'b00: begin
                fmtStrb = 4'b0001 << d_addr[1:0];
                fmtData = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                dMisaligned = d_addr[0];
                fmtStrb     = 4'b0011 << d_addr[1:0];
                fmtData     = {2{d_wdata[15:0]}};
            end
            2'b10: begin
                dMisaligned = |d_addr[1:0];
                fmtStrb     = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (offset)
            2'd0:    selByte = mem_rdata[7:0];
            2'd1:    selByte = mem_rdata[15:8];
            2'd2:    selByte = mem_rdata[23:16];
            default: selByte = mem_rdata[31:24];
        endcase
        selHalf = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (width)
            3'b000:  loadData = {{24{selByte[7]}}, selByte};
            3'b001:  loadData = {{16{selHalf[15]}}, selHalf};
            3'b100:  loadData = {24'd0, selByte};
            3'b101:  loadData = {16'd0, selHalf};
            default: loadData = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            cnt       <= '0;
            lastData  <= 1'b0;
            grantData <= 1'b0;
            width     <= 3'b000;
            offset    <= 2'b00;
            if_done   <= 1'b0;
            if_rdata  <= '0;
            if_err    <= 1'b0;
            d_done    <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= 4'b0000;
        end else begin
            // Response outputs live for the single RESP cycle only.
            if_done  <= 1'b0;
            if_rdata <= '0;
            if_err   <= 1'b0;
            d_done   <= 1'b0;
            d_rdata  <= '0;
            d_err    <= 1'b0;
            case (state)
                StIdle: begin
                    if (d_req || if_req) begin
                        grantData <= pickData;
                        cnt       <= '0;
                        if (pickData) begin
                            width  <= d_width;
                            offset <= d_addr[1:0];
                            if (!widthOk || dMisaligned) begin
                                state  <= StResp;
                                d_done <= 1'b1;
                                d_err  <= 1'b1;
                            end else begin
                                state     <= StAcc;
                                mem_req   <= 1'b1;
                                mem_we    <= d_we;
                                mem_addr  <= {d_addr[31:2], 2'b00};
                                mem_wdata <= d_we ? fmtData : '0;
                                mem_wstrb <= d_we ? fmtStrb : 4'b0000;
                            end
                        end else if (|if_addr[1:0]) begin
                            state   <= StResp;
                            if_done <= 1'b1;
                            if_err  <= 1'b1;
                        end else begin
                            state     <= StAcc;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= {if_addr[31:2], 2'b00};
                            mem_wdata <= '0;
                            mem_wstrb <= 4'b0000;
                        end
                    end
                end
                StAcc: begin
                    if (mem_ack || cnt == CW'(TIMEOUT - 1)) begin
                        state     <= StResp;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'b0000;
                        if (grantData) begin
                            d_done  <= 1'b1;
                            d_err   <= ~mem_ack;
                            d_rdata <= (mem_ack && !mem_we) ? loadData : '0;
                        end else begin
                            if_done  <= 1'b1;
                            if_err   <= ~mem_ack;
                            if_rdata <= mem_ack ? mem_rdata : '0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                StResp: begin
                    lastData <= grantData;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_width;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .TIMEOUT(16),
        .CW     (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_rdata (if_rdata),
        .if_err   (if_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_width  (d_width),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; d_width = 0; mem_ack = 0; mem_rdata = 0;
        step(); step();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        total++; if (if_done !== 1'b0 || d_done !== 1'b0) begin
            bad++; $display("FAIL reset_done got if=%b d=%b want 0 0", if_done, d_done); end
        total++; if (mem_wstrb !== 4'b0 || mem_addr !== 32'h0) begin
            bad++; $display("FAIL reset_mem_bus got strb=%b addr=%h want 0", mem_wstrb, mem_addr); end
        total++; if (d_rdata !== 32'h0 || if_rdata !== 32'h0) begin
            bad++; $display("FAIL reset_rdata got d=%h if=%h want 0", d_rdata, if_rdata); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_fetch();
        if_req = 1; if_addr = 32'h100; mem_ack = 1; mem_rdata = 32'h0050_0093;
        #1;
        total++; if (stall_if !== 1'b1 || mem_req !== 1'b0) begin
            bad++; $display("FAIL fetch_c1 got stall=%b req=%b want 1 0", stall_if, mem_req); end
        step();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_wstrb !== 4'b0) begin
            bad++; $display("FAIL fetch_c2_bus got req=%b addr=%h we=%b strb=%b want 1 100 0 0000",
                            mem_req, mem_addr, mem_we, mem_wstrb); end
        total++; if (stall_if !== 1'b1 || if_done !== 1'b0) begin
            bad++; $display("FAIL fetch_c2_stall got stall=%b done=%b want 1 0", stall_if, if_done); end
        step();
        total++; if (if_done !== 1'b1 || if_rdata !== 32'h0050_0093 || if_err !== 1'b0) begin
            bad++; $display("FAIL fetch_c3_done got done=%b rdata=%h err=%b want 1 00500093 0",
                            if_done, if_rdata, if_err); end
        total++; if (stall_if !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL fetch_c3_stall got stall=%b req=%b want 0 0", stall_if, mem_req); end
        if_req = 0; mem_ack = 0;
        step();
        total++; if (if_done !== 1'b0) begin bad++; $display("FAIL fetch_c4_done got %b want 0", if_done); end
    endtask

    task automatic test_back_to_back();
        d_req = 1; d_we = 0; d_addr = 32'h300; d_width = 3'b010;
        if_req = 1; if_addr = 32'h104; mem_ack = 1; mem_rdata = 32'h1122_3344;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) step(); else #1;
            total++; if (d_done !== (c % 6 == 3) || if_done !== (c % 6 == 0)) begin
                bad++; $display("FAIL b2b_order cycle %0d got d=%b if=%b want d=%b if=%b",
                                c, d_done, if_done, (c % 6 == 3), (c % 6 == 0)); end
            if (c % 3 == 0) begin
                total++; if (d_rdata !== (c % 6 == 3 ? 32'h1122_3344 : 32'h0) ||
                             if_rdata !== (c % 6 == 0 ? 32'h1122_3344 : 32'h0)) begin
                    bad++; $display("FAIL b2b_rdata cycle %0d got d=%h if=%h", c, d_rdata, if_rdata); end
            end
        end
        d_req = 0; if_req = 0; mem_ack = 0;
        step();
    endtask

    task automatic test_store(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] w,
                              input logic [3:0] expStrb, input logic [31:0] expData);
        d_req = 1; d_we = 1; d_addr = addr; d_wdata = wd; d_width = w; mem_ack = 0;
        step();
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== {addr[31:2], 2'b00}) begin
            bad++; $display("FAIL store_bus got req=%b we=%b addr=%h want 1 1 %h",
                            mem_req, mem_we, mem_addr, {addr[31:2], 2'b00}); end
        total++; if (mem_wstrb !== expStrb || mem_wdata !== expData) begin
            bad++; $display("FAIL store_fmt got strb=%b wdata=%h want %b %h",
                            mem_wstrb, mem_wdata, expStrb, expData); end
        mem_ack = 1;
        step();
        total++; if (d_done !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'h0) begin
            bad++; $display("FAIL store_done got done=%b err=%b rdata=%h want 1 0 0", d_done, d_err, d_rdata); end
        d_req = 0; d_we = 0; mem_ack = 0;
        step();
    endtask

    task automatic test_load(input logic [31:0] addr, input logic [2:0] w, input logic [31:0] word,
                             input logic [31:0] expData);
        d_req = 1; d_we = 0; d_addr = addr; d_width = w; mem_ack = 1; mem_rdata = word;
        step();
        total++; if (mem_req !== 1'b1 || mem_wstrb !== 4'b0 || mem_addr !== {addr[31:2], 2'b00}) begin
            bad++; $display("FAIL load_bus got req=%b strb=%b addr=%h", mem_req, mem_wstrb, mem_addr); end
        step();
        total++; if (d_done !== 1'b1 || d_err !== 1'b0 || d_rdata !== expData) begin
            bad++; $display("FAIL load_data addr=%h w=%b got done=%b err=%b rdata=%h want 1 0 %h",
                            addr, w, d_done, d_err, d_rdata, expData); end
        d_req = 0; mem_ack = 0;
        step();
    endtask

    task automatic test_misaligned(input logic isData, input logic [31:0] addr, input logic [2:0] w);
        mem_ack = 0;
        if (isData) begin d_req = 1; d_we = 0; d_addr = addr; d_width = w; end
        else begin if_req = 1; if_addr = addr; end
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL misalign_c1_req got %b want 0", mem_req); end
        step();
        total++; if ((isData ? d_done : if_done) !== 1'b1 || (isData ? d_err : if_err) !== 1'b1
                     || mem_req !== 1'b0) begin
            bad++; $display("FAIL misalign_c2 addr=%h got d=%b/%b if=%b/%b req=%b",
                            addr, d_done, d_err, if_done, if_err, mem_req); end
        d_req = 0; if_req = 0;
        step();
    endtask

    task automatic test_timeout();
        int reqCnt  = 0;
        int doneCyc = 0;
        logic errSeen = 1'b0;
        logic [31:0] rdSeen = 32'hdead_beef;
        d_req = 1; d_we = 0; d_addr = 32'h500; d_width = 3'b010; mem_ack = 0; mem_rdata = 32'hffff_ffff;
        for (int c = 2; c <= 40 && doneCyc == 0; c++) begin
            step();
            if (mem_req) reqCnt++;
            if (d_done) begin doneCyc = c; errSeen = d_err; rdSeen = d_rdata; end
        end
        total++; if (reqCnt != 16) begin bad++; $display("FAIL timeout_req_cycles got %0d want 16", reqCnt); end
        total++; if (doneCyc != 18) begin bad++; $display("FAIL timeout_done_cycle got %0d want 18", doneCyc); end
        total++; if (errSeen !== 1'b1 || rdSeen !== 32'h0) begin
            bad++; $display("FAIL timeout_resp got err=%b rdata=%h want 1 0", errSeen, rdSeen); end
        d_req = 0;
        step();
    endtask

    task automatic test_reset_mid();
        d_req = 1; d_we = 0; d_addr = 32'h600; d_width = 3'b010; mem_ack = 0;
        step();
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rstmid_acc got req=%b want 1", mem_req); end
        reset = 1;
        step();
        total++; if (mem_req !== 1'b0 || d_done !== 1'b0) begin
            bad++; $display("FAIL rstmid_after got req=%b done=%b want 0 0", mem_req, d_done); end
        reset = 0; d_req = 0; mem_ack = 1;
        for (int c = 0; c < 4; c++) begin
            step();
            total++; if (mem_req !== 1'b0 || d_done !== 1'b0 || if_done !== 1'b0) begin
                bad++; $display("FAIL rstmid_idle cycle %0d got req=%b d=%b if=%b want 0 0 0",
                                c, mem_req, d_done, if_done); end
        end
        mem_ack = 0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_back_to_back();
        test_store(32'h203, 32'h0000_00ab, 3'b000, 4'b1000, 32'habab_abab);
        test_store(32'h202, 32'h1234_abcd, 3'b001, 4'b1100, 32'habcd_abcd);
        test_store(32'h208, 32'hcafe_f00d, 3'b010, 4'b1111, 32'hcafe_f00d);
        test_load(32'h402, 3'b001, 32'h8001_1234, 32'hffff_8001);
        test_load(32'h402, 3'b101, 32'h8001_1234, 32'h0000_8001);
        test_load(32'h401, 3'b000, 32'h8001_1234, 32'h0000_0012);
        test_load(32'h403, 3'b000, 32'h8001_1234, 32'hffff_ff80);
        test_load(32'h403, 3'b100, 32'h8001_1234, 32'h0000_0080);
        test_load(32'h400, 3'b010, 32'h8001_1234, 32'h8001_1234);
        test_misaligned(1'b1, 32'h401, 3'b010);
        test_misaligned(1'b1, 32'h403, 3'b001);
        test_misaligned(1'b1, 32'h400, 3'b011);
        test_misaligned(1'b0, 32'h102, 3'b000);
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the instruction-fetch stage and the data-memory stage of the 5-stage pipeline.
- Sequences each access through a request/ack handshake and formats store strobes and load data by access width.
- Enforces a timeout on every memory access.
- Produces stall outputs consumed by the hazard logic to freeze the fetch stage and the memory stage.

Parameters:
- TIMEOUT, 16: max cycles mem_req stays high without mem_ack before the access is aborted (1..255).
- CW, 8: width of the timeout counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_done
- if_addr  in  32  fetch address (word aligned)
- if_done  out  1  one-cycle pulse: fetch complete
- if_rdata  out  32  fetched instruction, valid with if_done
- if_err  out  1  valid with if_done: fetch timed out or misaligned
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_width until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  byte address
- d_wdata  in  32  store data (low bytes significant)
- d_width  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
- d_done  out  1  one-cycle pulse: data access complete
- d_rdata  out  32  extended load result, valid with d_done (0 for stores)
- d_err  out  1  valid with d_done: timeout, misaligned, or illegal width
- stall_if  out  1  if_req & ~if_done (combinational)
- stall_mem  out  1  d_req & ~d_done (combinational)
- mem_req  out  1  memory access strobe, held until mem_ack or abort
- mem_we  out  1  write enable
- mem_addr  out  32  word address ({addr[31:2],2'b00})
- mem_wdata  out  32  store data replicated into byte lanes
- mem_wstrb  out  4  byte-lane write enables
- mem_ack  in  1  access accepted/complete; mem_rdata valid same cycle
- mem_rdata  in  32  read word

Behaviour:

Reset values and reset mid-operation
- Reset: state IDLE, counter 0, last_grant=fetch.
- Reset: all outputs 0 except the combinational stall outputs.
- Reset mid-operation: next edge returns to IDLE with mem_req=0; any mem_ack arriving afterwards is ignored.

State machine (registered: IDLE, ACC, RESP)
- IDLE, no request pending: stay in IDLE.
- IDLE, request pending: latch the winner's attributes, go to ACC.
- Arbitration:
  - Only d_req pending: data wins.
  - Only if_req pending: fetch wins.
  - Both pending: data wins unless last_grant=data, in which case fetch wins. Consecutive grants therefore alternate and neither requester starves.
- Data pre-check in IDLE: misaligned access (h with addr[0]=1; w with addr[1:0]!=0) or illegal width goes directly to RESP with err=1 and no mem_req. Fetch with if_addr[1:0]!=0 is handled the same way.
- ACC: mem_req=1; mem_we/addr/wdata/wstrb driven from latched values and stable throughout. The counter increments each cycle.
  - mem_ack=1: capture mem_rdata, go to RESP with err=0.
  - Counter reaches TIMEOUT-1 without ack: drop mem_req, go to RESP with err=1, rdata=0.
- RESP: assert the granted requester's done for exactly one cycle with rdata/err, update last_grant, go to IDLE. Requests are not sampled in RESP.
- Latency: minimum 3 cycles from request to done (IDLE, ACC with immediate ack, RESP).

Write formatting
- b: wstrb = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
- h: wstrb = 0011 << addr[1:0]; wdata = {2{wdata[15:0]}}.
- w: wstrb = 1111; wdata passed through.
- Loads and fetches: wstrb = 0000, mem_we=0.

Load extraction
- Byte selected by addr[1:0]; halfword selected by addr[1].
- b and h sign-extend; bu and hu zero-extend; w passes the word through.
- if_rdata = raw word.

Other rules
- Only one of if_done/d_done is ever high in a given cycle.
- A requester dropping req while in ACC does not abort the access; done still pulses.

Test Plan:
- Fetch only, if_addr=0x100, mem_ack on first ACC cycle with rdata=0x00500093: mem_req high 1 cycle, if_done on cycle 3 with if_rdata=0x00500093, if_err=0; stall_if high cycles 1-2.
- Both requests asserted continuously, ack immediate: grant order data, fetch, data, fetch; each done separated by 3 cycles.
- Store byte d_addr=0x203, d_wdata=0xAB: mem_addr=0x200, mem_wstrb=1000, mem_wdata=0xABABABAB.
- Load halfword d_addr=0x402, mem_rdata=0x8001_1234: d_rdata=0xFFFF8001. Same access as hu: d_rdata=0x00008001.
- Lw d_addr=0x401: no mem_req, d_done 2 cycles after request with d_err=1.
- mem_ack never asserted, TIMEOUT=16: mem_req high exactly 16 cycles, then d_done with d_err=1, d_rdata=0. Reset asserted mid-ACC: mem_req=0 next cycle, no done.
